// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// hazard_scoreboard_pkg
// Shared constants and types for the hazard scoreboard and its sub-modules.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

   localparam logic [2:0] c_fwdRf = 3'd0;

   localparam int c_stgE = 0;
   localparam int c_stgM = 1;
   localparam int c_stgW = 2;

   localparam int c_v0Reg = 2;
   localparam int c_a0Reg = 4;

   typedef struct packed {
      logic load;
      logic branch;
      logic sys;
      logic md;
   } stallCause_t;

endpackage

`default_nettype wire

// File: rtl/hazard_md_timer.sv
// ============================================================================
// hazard_md_timer
// HI/LO busy timer: loads MD_LAT on a mult/div issue, counts down to zero.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_md_timer #(
   parameter int MD_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   output logic o_busy
);

   localparam int c_cntW = $clog2(MD_LAT + 1);

   logic [c_cntW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= c_cntW'(MD_LAT);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard
// Decode-side hazard/forwarding unit with a shadow pipeline of in-flight
// writers. Optional stall statistics are built when HAZARD_STATS_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NSTG     = 3,
   parameter int LOAD_RDY = c_stgW,
   parameter int BR_SAFE  = c_stgM,
   parameter int MD_LAT   = 32,
   parameter int V0_REG   = c_v0Reg,
   parameter int A0_REG   = c_a0Reg,
   parameter int STAT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_d,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic              use_rs_d,
   input  logic              use_rt_d,
   input  logic [REG_AW-1:0] dest_d,
   input  logic              regwrite_d,
   input  logic              memtoreg_d,
   input  logic              branch_d,
   input  logic              syscall_d,
   input  logic              md_start_d,
   input  logic              md_read_d,
   output logic              en_f,
   output logic              en_d,
   output logic              flush_e,
   output logic [2:0]        fwd_a_e,
   output logic [2:0]        fwd_b_e,
   output logic [STAT_W-1:0] stat_total,
   output logic [STAT_W-1:0] stat_load,
   output logic [STAT_W-1:0] stat_branch,
   output logic [STAT_W-1:0] stat_sys,
   output logic [STAT_W-1:0] stat_md
);

   typedef struct packed {
      logic              vld;
      logic              wr;
      logic              ld;
      logic [REG_AW-1:0] dest;
   } shadow_t;

   shadow_t           r_shd [NSTG];
   logic [REG_AW-1:0] r_rsE;
   logic [REG_AW-1:0] r_rtE;

   logic [NSTG-1:0]   w_live;
   logic [NSTG-1:0]   w_hitSrc;
   logic [NSTG-1:0]   w_hitSys;
   logic [NSTG-1:0]   w_hitA;
   logic [NSTG-1:0]   w_hitB;
   stallCause_t       w_cause;
   logic              w_stall;
   logic              w_advance;
   logic              w_mdBusy;

   // Only E needs its source registers; later stages are matched on dest alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NSTG; k++) begin
            r_shd[k] <= '0;
         end
         r_rsE <= '0;
         r_rtE <= '0;
      end else begin
         r_shd[c_stgE] <= '{vld: w_advance, wr: regwrite_d, ld: memtoreg_d, dest: dest_d};
         r_rsE         <= rs_d;
         r_rtE         <= rt_d;
         for (int k = 1; k < NSTG; k++) begin
            r_shd[k] <= r_shd[k-1];
         end
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_cmp
      assign w_live[k]   = r_shd[k].vld & r_shd[k].wr & (r_shd[k].dest != '0);
      assign w_hitSrc[k] = w_live[k] & ((use_rs_d & (r_shd[k].dest == rs_d)) |
                                        (use_rt_d & (r_shd[k].dest == rt_d)));
      assign w_hitSys[k] = w_live[k] & ((r_shd[k].dest == REG_AW'(V0_REG)) |
                                        (r_shd[k].dest == REG_AW'(A0_REG)));
      assign w_hitA[k]   = w_live[k] & (r_shd[k].dest == r_rsE);
      assign w_hitB[k]   = w_live[k] & (r_shd[k].dest == r_rtE);
   end

   always_comb begin
      w_cause = '0;
      for (int k = 0; k < NSTG; k++) begin
         if (w_hitSrc[k] && r_shd[k].ld && (k < LOAD_RDY - 1)) begin
            w_cause.load = 1'b1;
         end
         if (branch_d && w_hitSrc[k] && ((k < BR_SAFE) || (r_shd[k].ld && (k < LOAD_RDY)))) begin
            w_cause.branch = 1'b1;
         end
         if (syscall_d && w_hitSys[k]) begin
            w_cause.sys = 1'b1;
         end
      end
      w_cause.md = (md_read_d | md_start_d) & w_mdBusy;
   end

   assign w_stall   = issue_d & (w_cause.load | w_cause.branch | w_cause.sys | w_cause.md);
   assign w_advance = issue_d & ~w_stall;
   assign en_f      = ~w_stall;
   assign en_d      = ~w_stall;
   assign flush_e   = w_stall;

   // Walk oldest to youngest so the youngest producer overrides.
   always_comb begin
      fwd_a_e = c_fwdRf;
      fwd_b_e = c_fwdRf;
      for (int k = NSTG - 1; k >= c_stgM; k--) begin
         if (r_shd[c_stgE].vld && w_hitA[k]) fwd_a_e = 3'(k);
         if (r_shd[c_stgE].vld && w_hitB[k]) fwd_b_e = 3'(k);
      end
   end

   hazard_md_timer #(
      .MD_LAT (MD_LAT)
   ) u_mdTimer (
      .clk    (clk),
      .rst    (reset),
      .i_load (md_start_d & w_advance),
      .o_busy (w_mdBusy)
   );

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] r_statTotal, r_statLoad, r_statBranch, r_statSys, r_statMd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_statTotal  <= '0;
         r_statLoad   <= '0;
         r_statBranch <= '0;
         r_statSys    <= '0;
         r_statMd     <= '0;
      end else begin
         if (w_stall && (r_statTotal != '1))                       r_statTotal  <= r_statTotal + 1'b1;
         if (issue_d && w_cause.load && (r_statLoad != '1))        r_statLoad   <= r_statLoad + 1'b1;
         if (issue_d && w_cause.branch && (r_statBranch != '1))    r_statBranch <= r_statBranch + 1'b1;
         if (issue_d && w_cause.sys && (r_statSys != '1))          r_statSys    <= r_statSys + 1'b1;
         if (issue_d && w_cause.md && (r_statMd != '1))            r_statMd     <= r_statMd + 1'b1;
      end
   end

   assign stat_total  = r_statTotal;
   assign stat_load   = r_statLoad;
   assign stat_branch = r_statBranch;
   assign stat_sys    = r_statSys;
   assign stat_md     = r_statMd;
`else
   assign stat_total  = '0;
   assign stat_load   = '0;
   assign stat_branch = '0;
   assign stat_sys    = '0;
   assign stat_md     = '0;
`endif

endmodule

`default_nettype wire
